// File: rtl/fwm_pkg.sv
// rtl/fwm_pkg.sv - shared encodings and 3x3 tap geometry for the frame window store
package fwm_pkg;

    typedef enum logic [1:0] {
        OP_WIN   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_WIN,
        S_WR,
        S_RD,
        S_RSP
    } state_e;

    localparam int TAPS      = 9;
    // one read slot per tap plus the final capture cycle
    localparam int WIN_STEPS = TAPS + 1;

    // tap k sits at (row-1 + k%3, col-1 + k/3): row varies fastest
    function automatic int tap_drow(input int k);
        return (k % 3) - 1;
    endfunction

    function automatic int tap_dcol(input int k);
        return (k / 3) - 1;
    endfunction

endpackage

// File: rtl/fwm_ram.sv
// rtl/fwm_ram.sv - single-port synchronous RAM with one-cycle registered read
module fwm_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/frame_window_mem.sv
// rtl/frame_window_mem.sv - raster-loaded frame store serving 3x3 window, write and read commands
module frame_window_mem
    import fwm_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int ROWS      = 430,
    parameter int COLS      = 554,
    parameter int EDGE_MODE = 0,
    parameter int RA_W      = $clog2(ROWS),
    parameter int CA_W      = $clog2(COLS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [PIX_W-1:0]   load_data,
    output logic               load_ready,
    output logic               load_done,
    input  logic               reload,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [RA_W-1:0]    cmd_row,
    input  logic [CA_W-1:0]    cmd_col,
    input  logic [PIX_W-1:0]   cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_err,
    output logic [PIX_W-1:0]   rsp_pixel,
    output logic [9*PIX_W-1:0] rsp_window
);

    localparam int AW = $clog2(ROWS * COLS);
    // two spare bits so row+1 on a power-of-two image cannot wrap negative
    localparam int RW = RA_W + 2;
    localparam int CW = CA_W + 2;

    state_e state, state_nxt;

    logic [RA_W-1:0]  ld_row, row_q, tap_row;
    logic [CA_W-1:0]  ld_col, col_q, tap_col;
    op_e              op_q;
    logic [PIX_W-1:0] data_q;
    logic [3:0]       cnt;
    logic             oob_q;

    logic             ram_en, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [PIX_W-1:0] ram_wdata, ram_rdata, tap_val;

    logic             load_last, cmd_bad;
    logic signed [RW-1:0] tap_r;
    logic signed [CW-1:0] tap_c;
    logic             tap_oob;

    function automatic logic [AW-1:0] lin_addr(input logic [RA_W-1:0] r, input logic [CA_W-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    assign load_last = (ld_row == RA_W'(ROWS - 1)) && (ld_col == CA_W'(COLS - 1));
    assign cmd_bad   = (int'(cmd_row) >= ROWS) || (int'(cmd_col) >= COLS) || (cmd_op == OP_RSVD);
    assign tap_val   = oob_q ? '0 : ram_rdata;

    always_comb begin
        tap_r   = $signed({2'b00, row_q}) + RW'(tap_drow(int'(cnt)));
        tap_c   = $signed({2'b00, col_q}) + CW'(tap_dcol(int'(cnt)));
        tap_oob = (int'(tap_r) < 0) || (int'(tap_r) >= ROWS) ||
                  (int'(tap_c) < 0) || (int'(tap_c) >= COLS);
        tap_row = tap_r[RA_W-1:0];
        tap_col = tap_c[CA_W-1:0];
        if (int'(tap_r) < 0)          tap_row = '0;
        else if (int'(tap_r) >= ROWS) tap_row = RA_W'(ROWS - 1);
        if (int'(tap_c) < 0)          tap_col = '0;
        else if (int'(tap_c) >= COLS) tap_col = CA_W'(COLS - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (load_valid && load_last) state_nxt = S_IDLE;
            S_IDLE: begin
                if (reload) begin
                    state_nxt = S_LOAD;
                end else if (cmd_valid) begin
                    if (cmd_bad)                state_nxt = S_RSP;
                    else if (cmd_op == OP_WIN)  state_nxt = S_WIN;
                    else if (cmd_op == OP_WRITE) state_nxt = S_WR;
                    else                        state_nxt = S_RD;
                end
            end
            S_WIN:  if (cnt == 4'(WIN_STEPS - 1)) state_nxt = S_RSP;
            S_WR:   state_nxt = S_RSP;
            S_RD:   if (cnt == 4'd1) state_nxt = S_RSP;
            S_RSP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        load_ready = (state == S_LOAD);
        cmd_ready  = (state == S_IDLE) && !reload;
        rsp_valid  = (state == S_RSP);
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            S_LOAD: begin
                ram_en    = load_valid;
                ram_we    = load_valid;
                ram_addr  = lin_addr(ld_row, ld_col);
                ram_wdata = load_data;
            end
            S_WIN: begin
                ram_en   = (cnt < 4'(TAPS)) && !((EDGE_MODE == 0) && tap_oob);
                ram_addr = lin_addr(tap_row, tap_col);
            end
            S_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = lin_addr(row_q, col_q);
                ram_wdata = data_q;
            end
            S_RD: begin
                ram_en   = (cnt == 4'd0);
                ram_addr = lin_addr(row_q, col_q);
            end
            default: ;
        endcase
    end

    fwm_ram #(
        .W     (PIX_W),
        .DEPTH (ROWS * COLS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_row     <= '0;
            ld_col     <= '0;
            load_done  <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            op_q       <= OP_WIN;
            data_q     <= '0;
            cnt        <= '0;
            oob_q      <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_pixel  <= '0;
            rsp_window <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_valid) begin
                        if (load_last) begin
                            ld_row    <= '0;
                            ld_col    <= '0;
                            load_done <= 1'b1;
                        end else if (ld_col == CA_W'(COLS - 1)) begin
                            ld_col <= '0;
                            ld_row <= ld_row + 1'b1;
                        end else begin
                            ld_col <= ld_col + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (reload) begin
                        ld_row    <= '0;
                        ld_col    <= '0;
                        load_done <= 1'b0;
                    end else if (cmd_valid) begin
                        op_q       <= op_e'(cmd_op);
                        row_q      <= cmd_row;
                        col_q      <= cmd_col;
                        data_q     <= cmd_data;
                        cnt        <= '0;
                        oob_q      <= 1'b0;
                        rsp_err    <= cmd_bad;
                        rsp_pixel  <= '0;
                        rsp_window <= '0;
                    end
                end
                S_WIN: begin
                    cnt   <= cnt + 1'b1;
                    oob_q <= (EDGE_MODE == 0) && tap_oob;
                    // tap k's RAM data arrives one cycle after its read slot
                    for (int k = 0; k < TAPS; k++) begin
                        if (cnt == 4'(k + 1)) rsp_window[k*PIX_W +: PIX_W] <= tap_val;
                    end
                end
                S_RD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 4'd1) rsp_pixel <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
